// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

  // One-hot owner encoding so the state register can drive gnt_o directly.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts strobed cycles without a slave response and pulses
// timeout_o on the cycle the count reaches TIMEOUT (0 disables it).
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic stb_i,
  input  logic resp_i,
  output logic timeout_o
);

  localparam int              CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]   LIMIT   = CW'(TIMEOUT);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam bit              ENABLED = (TIMEOUT > 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hit;

  // A real slave response in the limit cycle wins over the synthetic error.
  assign hit       = ENABLED && stb_i && !resp_i && (cnt_q == LIMIT);
  assign timeout_o = hit;

  always_comb begin
    cnt_d = cnt_q;
    if (!ENABLED || !stb_i || resp_i || hit) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: m0 is the core, m1 the loader/DMA. Ownership is
// held for a whole bus cycle; ties go to the master that did not own last.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_wen_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_wen_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_wen_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  gnt_o
);

  arb_state_e state_q;
  logic       last_q;
  logic       wd_timeout;

  // Handshake: a master owns the slave from the edge after cyc rises until
  // the edge after cyc falls; ack/err/rty reach only the owner, same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_q <= last_q ? OWN0 : OWN1;
          end else if (m0_cyc_i) begin
            state_q <= OWN0;
          end else if (m1_cyc_i) begin
            state_q <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            last_q  <= 1'b0;
            state_q <= m1_cyc_i ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            last_q  <= 1'b1;
            state_q <= m0_cyc_i ? OWN0 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o    = state_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_wen_o = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state_q)
      OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_wen_o = m0_wen_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_wen_o = m1_wen_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // Responses live in their own block so the watchdog path stays acyclic.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state_q)
      OWN0: begin
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_timeout;
        m0_rty_o = s_rty_i;
      end
      OWN1: begin
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_timeout;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .stb_i    (s_stb_o),
    .resp_i   (s_ack_i | s_err_i | s_rty_i),
    .timeout_o(wd_timeout)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: every master response is scored against
// an expected {master, ack, err, rty, data} entry queued with the stimulus.
module tb_bus_arbiter;

  localparam int W = 36;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc_i, m0_stb_i, m0_wen_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_wen_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_wen_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  bus_arbiter #(
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_wen_i(m0_wen_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_wen_i(m1_wen_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_wen_o(s_wen_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .gnt_o(gnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score(input logic m, input logic a, input logic e, input logic r,
                       input logic [31:0] d);
    logic [W-1:0] obs;
    obs = {m, a, e, r, d};
    if (exp_q.size() == 0) begin
      check("sb_unexpected", obs, '0);
    end else begin
      check("sb_resp", obs, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (m0_ack_o || m0_err_o || m0_rty_o) score(1'b0, m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o);
    if (m1_ack_o || m1_err_o || m1_rty_o) score(1'b1, m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {m0_cyc_i, m0_stb_i, m0_wen_i, m0_sel_i, m0_adr_i, m0_dat_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_wen_i, m1_sel_i, m1_adr_i, m1_dat_i} = '0;
    {s_dat_i, s_ack_i, s_err_i, s_rty_i} = '0;
  endtask

  task automatic drive_m(input int m, input logic on);
    if (m == 0) begin
      m0_cyc_i = on;
      m0_stb_i = on;
    end else begin
      m1_cyc_i = on;
      m1_stb_i = on;
    end
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    sample();
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
    step();
    reset = 1'b0;

    // Single master read of 0x1000, slave acks two cycles after the grant.
    drive_m(0, 1'b1);
    m0_sel_i = 4'hf;
    m0_adr_i = 32'h0000_1000;
    sample();
    check("arb_latency_gnt", gnt_o, 2'b00);
    check("idle_s_cyc", s_cyc_o, 1'b0);
    step();
    sample();
    check("single_gnt", gnt_o, 2'b01);
    check("single_s_adr", s_adr_o, 32'h0000_1000);
    check("single_s_cyc", s_cyc_o, 1'b1);
    check("single_s_sel", s_sel_o, 4'hf);
    step();
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'hCAFE_0001;
    exp_q.push_back({1'b0, 3'b100, 32'hCAFE_0001});
    sample();
    check("m1_dat_mirror", m1_dat_o, 32'hCAFE_0001);
    step();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0);
    sample();
    check("single_hold_gnt", gnt_o, 2'b01);
    step();
    sample();
    check("single_release_gnt", gnt_o, 2'b00);

    // Tie right after reset goes to m0, then direct handover to m1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    m1_adr_i = 32'h0000_2000;
    m1_sel_i = 4'h5;
    step();
    sample();
    check("tie_gnt", gnt_o, 2'b01);
    check("tie_s_adr", s_adr_o, 32'h0000_1000);
    step();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0011;
    exp_q.push_back({1'b0, 3'b100, 32'h0000_0011});
    sample();
    step();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0);
    step();
    sample();
    check("handover_gnt", gnt_o, 2'b10);
    check("handover_s_adr", s_adr_o, 32'h0000_2000);
    s_ack_i = 1'b1;
    s_dat_i = 32'h0000_0022;
    exp_q.push_back({1'b1, 3'b100, 32'h0000_0022});
    step();
    s_ack_i = 1'b0;
    drive_m(1, 1'b0);
    step();
    sample();
    check("handover_idle_gnt", gnt_o, 2'b00);

    // Back-to-back requests from both masters must alternate.
    drive_m(0, 1'b1);
    drive_m(1, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      s_ack_i = 1'b1;
      s_dat_i = d;
      exp_q.push_back({(i % 2 == 1), 3'b100, d});
      sample();
      check("fair_gnt", gnt_o, (i % 2 == 1) ? 2'b10 : 2'b01);
      step();
      s_ack_i = 1'b0;
      drive_m(i % 2, 1'b0);
      step();
      drive_m(i % 2, 1'b1);
    end
    drive_m(0, 1'b0);
    drive_m(1, 1'b0);
    step();
    sample();
    check("fair_idle_gnt", gnt_o, 2'b00);

    // Watchdog: m1 strobes with no slave response.
    drive_m(1, 1'b1);
    m1_adr_i = 32'h0000_3000;
    s_dat_i = 32'h0;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) exp_q.push_back({1'b1, 3'b010, 32'h0});
      sample();
      check($sformatf("wd_err_c%0d", c), m1_err_o, (c == 5));
      step();
    end
    drive_m(1, 1'b0);
    step();

    // Slave ack exactly on the limit cycle wins over the timeout.
    drive_m(0, 1'b1);
    s_dat_i = 32'h0000_5555;
    step();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        s_ack_i = 1'b1;
        exp_q.push_back({1'b0, 3'b100, 32'h0000_5555});
      end
      sample();
      check($sformatf("limit_no_err_c%0d", c), m0_err_o, 1'b0);
      step();
    end
    s_ack_i = 1'b0;
    sample();
    check("limit_after_err", m0_err_o, 1'b0);
    step();
    s_rty_i = 1'b1;
    exp_q.push_back({1'b0, 3'b001, 32'h0000_5555});
    sample();
    step();
    s_rty_i = 1'b0;
    drive_m(0, 1'b0);
    step();

    // Reset in the middle of an m0 write aborts it; then m0 wins the tie.
    drive_m(0, 1'b1);
    m0_wen_i = 1'b1;
    m0_sel_i = 4'h3;
    m0_adr_i = 32'h0000_4000;
    m0_dat_i = 32'hDEAD_BEEF;
    step();
    sample();
    check("wr_gnt", gnt_o, 2'b01);
    check("wr_s_wen", s_wen_o, 1'b1);
    check("wr_s_dat", s_dat_o, 32'hDEAD_BEEF);
    check("wr_s_sel", s_sel_o, 4'h3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_m(1, 1'b1);
    s_ack_i = 1'b1;
    sample();
    check("abort_gnt", gnt_o, 2'b00);
    check("abort_s_cyc", s_cyc_o, 1'b0);
    check("abort_m0_ack", m0_ack_o, 1'b0);
    s_ack_i = 1'b0;
    step();
    sample();
    check("post_reset_tie_gnt", gnt_o, 2'b01);
    clear_inputs();
    step();
    step();

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-watchdog limit in cycles; 0 disables the watchdog.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 m{0,1}_cyc_i  input  1  master bus-cycle request; m0 is the core, m1 is the loader/DMA.
REQ-005 m{0,1}_stb_i  input  1  master strobe.
REQ-006 m{0,1}_wen_i  input  1  master write enable.
REQ-007 m{0,1}_sel_i  input  4  master byte select.
REQ-008 m{0,1}_adr_i  input  32  master address.
REQ-009 m{0,1}_dat_i  input  32  master write data.
REQ-010 m{0,1}_dat_o  output  32  read data to master.
REQ-011 m{0,1}_ack_o  output  1  acknowledge to master.
REQ-012 m{0,1}_err_o  output  1  error to master.
REQ-013 m{0,1}_rty_o  output  1  retry to master.
REQ-014 s_cyc_o, s_stb_o, s_wen_o  output  1 each  slave cycle, strobe and write enable.
REQ-015 s_sel_o  output  4  slave byte select.
REQ-016 s_adr_o  output  32  slave address.
REQ-017 s_dat_o  output  32  slave write data.
REQ-018 s_dat_i  input  32  slave read data.
REQ-019 s_ack_i, s_err_i, s_rty_i  input  1 each  slave acknowledge, error and retry.
REQ-020 gnt_o  output  2  registered one-hot owner; 2'b00 when idle.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1; the state register drives gnt_o.
REQ-022 In IDLE, an asserted mx_cyc_i SHALL cause a transition to OWNx at the next edge, giving one cycle of arbitration latency.
REQ-023 When both masters request in IDLE, the master other than the last owner (register last) SHALL win.
REQ-024 In OWNx, all s_* outputs SHALL equal master x's inputs combinationally.
REQ-025 In OWNx, mx_ack_o/err_o/rty_o SHALL follow the slave inputs, and the other master's ack/err/rty SHALL be 0.
REQ-026 In IDLE, all s_* outputs and all master ack/err/rty outputs SHALL be 0.
REQ-027 m0_dat_o and m1_dat_o SHALL always equal s_dat_i.
REQ-028 Ownership SHALL be held while mx_cyc_i=1, with no preemption.
REQ-029 When the owner drops cyc and the other master requests, the FSM SHALL go directly OWNx->OWNy with no IDLE cycle; otherwise it SHALL go to IDLE.
REQ-030 On every ownership release, last SHALL be set to the releasing master.
REQ-031 Watchdog counter: cleared when s_stb_o=0 or any of s_ack_i/s_err_i/s_rty_i=1; otherwise increments.
REQ-032 When the watchdog count reaches TIMEOUT, the owner's err_o SHALL assert for exactly one cycle and the counter SHALL clear; the counter SHALL saturate and never wrap.
REQ-033 A slave ack/err/rty arriving in the same cycle as a timeout SHALL take priority: it is forwarded unchanged and no synthetic error is raised.

Reset
REQ-034 Reset SHALL force: state=IDLE, gnt_o=2'b00, last=1 (so m0 wins the first tie), watchdog=0, and all registered outputs to 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer: s_cyc_o=0 and all master acks=0 in the following cycle, with no partial handshake delivered.

Structure
REQ-036 A shared package SHALL hold the state enum (IDLE/OWN0/OWN1) and the default TIMEOUT constant.
REQ-037 One sub-module, bus_watchdog (counter, clear inputs, timeout pulse output), SHALL implement REQ-031..033.

Verification
REQ-038 Single master: m0 reads 0x1000 and the slave acks after 2 cycles -> gnt_o=01 one cycle after cyc, m0_ack_o pulses once, m1 sees no ack.
REQ-039 Tie after reset: both cyc rise together -> m0 granted first; m0 releases -> m1 granted at the next edge with no IDLE cycle.
REQ-040 Fairness: both masters issue continuous back-to-back requests -> grants strictly alternate 01,10,01,10.
REQ-041 Timeout with TIMEOUT=4: m1 strobes and the slave never acks -> m1_err_o=1 on exactly the 5th stb cycle, then 0.
REQ-042 Ack on the limit cycle: the slave acks exactly on that cycle -> ack forwarded and no err.
REQ-043 Reset mid-write by m0 -> next cycle s_cyc_o=0, gnt_o=00; after release the tie goes to m0.
